// File: rtl/nibbler_loader_pkg.sv
// Shared types and constants for the Nibbler program loader.
// Optional checksum stage: NIBBLER_LOADER_CSUM_EN.
package nibbler_loader_pkg;

  localparam int AW = 12;
  localparam int BW = 8;
  localparam logic [3:0] SYNC_DEF = 4'hA;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/nibbler_loader_csum.sv
// 8-bit running-sum accumulator for frame checksums.
// Used only when NIBBLER_LOADER_CSUM_EN is defined.
module nibbler_loader_csum
  import nibbler_loader_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          add,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] sum
);

  logic [BW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr)
      sum_d = '0;
    else if (add)
      sum_d = sum_q + din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      sum_q <= '0;
    else
      sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/nibbler_prog_loader.sv
// Framed host-to-program-memory loader; holds the CPU until done.
// Optional checksum stage: NIBBLER_LOADER_CSUM_EN.
module nibbler_prog_loader
  import nibbler_loader_pkg::*;
#(
  parameter logic [3:0] SYNC_NIB      = SYNC_DEF,
  parameter bit         HOLD_ON_RESET = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [BW-1:0] s_data,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [BW-1:0] mem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  state_e        state_q, state_d;
  logic [3:0]    hi_q, hi_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [BW-1:0] wdata_q, wdata_d;
  logic          xfer;

  assign xfer = s_valid & s_ready;

`ifdef NIBBLER_LOADER_CSUM_EN
  logic          csum_clr;
  logic          csum_add;
  logic [BW-1:0] csum_sum;
  logic [BW-1:0] csum_nx;

  assign csum_nx = csum_sum + s_data;

  nibbler_loader_csum u_csum (
    .clock (clock),
    .reset (reset),
    .clr   (csum_clr),
    .add   (csum_add),
    .din   (s_data),
    .sum   (csum_sum)
  );
`else
  // Holds off DONE one cycle so the last write never overlaps release.
  logic          fin_q, fin_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hi_q    <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
`ifndef NIBBLER_LOADER_CSUM_EN
      fin_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
`ifndef NIBBLER_LOADER_CSUM_EN
      fin_q   <= fin_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
`ifdef NIBBLER_LOADER_CSUM_EN
    csum_clr = 1'b0;
    csum_add = 1'b0;
`else
    fin_d    = fin_q;
`endif
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR_HI;
`ifdef NIBBLER_LOADER_CSUM_EN
          csum_clr = 1'b1;
`endif
        end
      end
      HDR_HI: begin
        if (xfer) begin
          hi_d    = s_data[3:0];
          state_d = (s_data[7:4] == SYNC_NIB)
                  ? HDR_LO : ERR;
`ifdef NIBBLER_LOADER_CSUM_EN
          csum_add = 1'b1;
`endif
        end
      end
      HDR_LO: begin
        if (xfer) begin
          rem_d   = {hi_q, s_data};
          addr_d  = '0;
          state_d = DATA;
`ifdef NIBBLER_LOADER_CSUM_EN
          csum_add = 1'b1;
`endif
        end
      end
      DATA: begin
`ifndef NIBBLER_LOADER_CSUM_EN
        if (fin_q) begin
          fin_d   = 1'b0;
          state_d = DONE;
        end
`endif
        if (xfer) begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = s_data;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
`ifdef NIBBLER_LOADER_CSUM_EN
          csum_add = 1'b1;
          if (rem_q == '0)
            state_d = CSUM;
`else
          if (rem_q == '0)
            fin_d = 1'b1;
`endif
        end
      end
      CSUM: begin
`ifdef NIBBLER_LOADER_CSUM_EN
        if (xfer)
          state_d = (csum_nx == '0) ? DONE : ERR;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (busy && abort) begin
      state_d = ERR;
`ifndef NIBBLER_LOADER_CSUM_EN
      fin_d   = 1'b0;
`endif
    end
  end

  always_comb begin
    s_ready  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state_q)
      IDLE: cpu_hold = HOLD_ON_RESET;
      HDR_HI, HDR_LO, CSUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      DATA: begin
`ifdef NIBBLER_LOADER_CSUM_EN
        s_ready = 1'b1;
`else
        s_ready = !fin_q;
`endif
        busy    = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR: error = 1'b1;
      default: ;
    endcase
  end

  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_nibbler_prog_loader.sv
// Self-checking bench for nibbler_prog_loader (vectors, random frames, corners).
// Honours NIBBLER_LOADER_CSUM_EN when the design is built with it.
module tb_nibbler_prog_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int n_chk;
  int n_fail;
  int cyc;

  logic [11:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  int          wlog_c[$];

  typedef struct {
    logic [7:0] h0;
    logic [7:0] h1;
    int         gap;
    bit         ok;
  } vec_t;

  vec_t tbl[8];

  nibbler_prog_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset && mem_we) begin
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
      wlog_c.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wlog_clear();
    wlog_a.delete();
    wlog_d.delete();
    wlog_c.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // gap: 0 none, 1 idle cycle before every byte, 2 random idle cycles
  task automatic send(input logic [7:0] b, input int gap);
    bit got;
    if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1))
      step();
    s_valid = 1'b1;
    s_data  = b;
    got     = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clock);
      got = s_ready;
      step();
    end
    s_valid = 1'b0;
    chk("send_ready", got, 1);
  endtask

  task automatic run_frame(input logic [7:0] h0, input logic [7:0] h1,
                           input int gap, input bit exp_ok,
                           input string nm);
    logic [7:0] d[$];
    logic [7:0] sum;
    int         n;
    wlog_clear();
    do_start();
    send(h0, gap);
    sum = h0;
    if (h0[7:4] == 4'hA) begin
      send(h1, gap);
      sum = sum + h1;
      n = {h0[3:0], h1} + 1;
      for (int i = 0; i < n; i++) begin
        d.push_back(8'($urandom));
        sum = sum + d[i];
        send(d[i], gap);
      end
`ifdef NIBBLER_LOADER_CSUM_EN
      send(8'(8'h00 - sum), gap);
`endif
    end
    repeat (3) step();
    chk({nm, " wcount"}, wlog_a.size(), d.size());
    for (int i = 0; i < d.size() && i < wlog_a.size(); i++) begin
      chk({nm, " waddr"}, wlog_a[i], i);
      chk({nm, " wdata"}, wlog_d[i], d[i]);
    end
    chk({nm, " done"}, done, exp_ok);
    chk({nm, " error"}, error, !exp_ok);
    chk({nm, " hold"}, cpu_hold, !exp_ok);
    chk({nm, " busy"}, busy, 0);
  endtask

  initial begin
    logic [7:0] rh0;
    logic [7:0] rh1;
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;

    tbl[0] = '{8'hA0, 8'h02, 0, 1'b1};
    tbl[1] = '{8'h50, 8'h00, 0, 1'b0};
    tbl[2] = '{8'hA0, 8'h03, 1, 1'b1};
    tbl[3] = '{8'hA1, 8'h05, 2, 1'b1};
    tbl[4] = '{8'hB0, 8'h00, 0, 1'b0};
    tbl[5] = '{8'hA0, 8'h00, 2, 1'b1};
    tbl[6] = '{8'h0A, 8'h00, 1, 1'b0};
    tbl[7] = '{8'hA0, 8'h1F, 2, 1'b1};

    // reset values
    repeat (2) @(negedge clock);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst s_ready", s_ready, 0);
    chk("rst cpu_hold", cpu_hold, 1);
    step();
    reset = 1'b1;
    step();

`ifndef NIBBLER_LOADER_CSUM_EN
    // short frame with exact write/release timing
    wlog_clear();
    do_start();
    chk("short s_ready", s_ready, 1);
    send(8'hA0, 0);
    do_start();
    chk("short start_ignored", busy, 1);
    send(8'h02, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    chk("short we_t1", mem_we, 1);
    chk("short addr_t1", mem_addr, 12'h002);
    chk("short data_t1", mem_wdata, 8'h33);
    chk("short done_t1", done, 0);
    chk("short hold_t1", cpu_hold, 1);
    step();
    chk("short done_t2", done, 1);
    chk("short hold_t2", cpu_hold, 0);
    chk("short we_t2", mem_we, 0);
    chk("short wcount", wlog_a.size(), 3);
    if (wlog_a.size() == 3) begin
      chk("short a0", {wlog_a[0], wlog_d[0]}, {12'h000, 8'h11});
      chk("short a1", {wlog_a[1], wlog_d[1]}, {12'h001, 8'h22});
      chk("short a2", {wlog_a[2], wlog_d[2]}, {12'h002, 8'h33});
      chk("short consec", wlog_c[2] - wlog_c[0], 2);
    end
`else
    // checksum good then bad
    wlog_clear();
    do_start();
    send(8'hA0, 0);
    send(8'h00, 0);
    send(8'h7F, 0);
    send(8'hE1, 0);
    chk("csum done", done, 1);
    chk("csum hold", cpu_hold, 0);
    chk("csum wcount", wlog_a.size(), 1);
    if (wlog_a.size() == 1)
      chk("csum w0", {wlog_a[0], wlog_d[0]}, {12'h000, 8'h7F});
    wlog_clear();
    do_start();
    send(8'hA0, 0);
    send(8'h00, 0);
    send(8'h7F, 0);
    send(8'hE2, 0);
    chk("csumbad error", error, 1);
    chk("csumbad hold", cpu_hold, 1);
    chk("csumbad wcount", wlog_a.size(), 1);
`endif

    // bad sync, then abort an open header
    wlog_clear();
    do_start();
    send(8'h50, 0);
    chk("sync error", error, 1);
    chk("sync hold", cpu_hold, 1);
    chk("sync s_ready", s_ready, 0);
    step();
    chk("sync no_we", wlog_a.size(), 0);
    do_start();
    chk("sync restart_ready", s_ready, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("hdr abort error", error, 1);
    chk("hdr abort busy", busy, 0);

    // abort + start collision mid-data
    wlog_clear();
    do_start();
    send(8'hA0, 0);
    send(8'h04, 0);
    send(8'h5A, 0);
    send(8'hC3, 0);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("coll error", error, 1);
    chk("coll busy", busy, 0);
    repeat (3) step();
    chk("coll wcount", wlog_a.size(), 2);
    if (wlog_a.size() == 2) begin
      chk("coll w0", {wlog_a[0], wlog_d[0]}, {12'h000, 8'h5A});
      chk("coll w1", {wlog_a[1], wlog_d[1]}, {12'h001, 8'hC3});
    end

    // table-driven frames
    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].h0, tbl[i].h1, tbl[i].gap, tbl[i].ok,
                $sformatf("vec%0d", i));

    // random frames against the reference rules
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 3) == 0)
        rh0 = {4'($urandom_range(0, 15)), 4'h0};
      else
        rh0 = {4'hA, 3'b000, 1'($urandom_range(0, 1))};
      rh1 = 8'($urandom);
      run_frame(rh0, rh1, 2, rh0[7:4] == 4'hA,
                $sformatf("rnd%0d", i));
    end

    // maximum frame
    run_frame(8'hAF, 8'hFF, 0, 1'b1, "full");
    if (wlog_a.size() > 0)
      chk("full last_addr", wlog_a[wlog_a.size() - 1], 12'hFFF);

    // reset mid-data
    do_start();
    send(8'hA0, 0);
    send(8'h09, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst mem_we", mem_we, 0);
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst mem_wdata", mem_wdata, 0);
    chk("midrst busy", busy, 0);
    chk("midrst s_ready", s_ready, 0);
    chk("midrst hold", cpu_hold, 1);
    step();
    reset = 1'b1;
    step();
    chk("postrst busy", busy, 0);
    chk("postrst done", done, 0);
    chk("postrst error", error, 0);
    chk("postrst s_ready", s_ready, 0);
    run_frame(8'hA0, 8'h05, 0, 1'b1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
